// File: rtl/btn_debounce_pkg.sv
// Shared constants and width helpers for the multi-channel button debouncer.
// Latency: none (package only).
// Backpressure: none (package only).
package btn_debounce_pkg;

    // Depth of the reset-release synchroniser in the top level.
    localparam int RST_SYNC_STAGES = 2;

    // Clock cycles per 1 ms tick.
    function automatic int tick_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, tick-based stability filter, press/release/long-press pulses.
// Latency: SYNC_STAGES cycles of sync, then DEBOUNCE_MS ticks of stable input before acceptance.
// Backpressure: none; event pulses are single-cycle and unconditional.
//   clk, rst_n      : clock and asynchronous active-low reset
//   raw, tick       : raw button bit and shared 1 ms tick
//   level           : debounced level (1 = pressed)
//   press_pulse / release_pulse / long_pulse : single-cycle events
module debounce_channel
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int   CW  = cnt_width(DEBOUNCE_MS);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic                   accept;

    // Polarity is normalised before the first flop so everything downstream is active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw ^ INV};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Acceptance needs DEBOUNCE_MS ticks while s differs from the current level.
    assign accept = (s != level) && tick && (cnt == CW'(DEBOUNCE_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // Pulses are registered alongside level so they line up with its first new cycle.
            press_pulse   <= accept && s;
            release_pulse <= accept && !s;
            // Agreement with the current level wins over a coincident tick.
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    generate
        if (LONG_PRESS_MS > 0) begin : g_long
            localparam int HW = cnt_width(LONG_PRESS_MS);
            logic [HW-1:0] hold;

            // hold saturates at LONG_PRESS_MS, so the pulse fires once per press.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold       <= '0;
                    long_pulse <= 1'b0;
                end else begin
                    long_pulse <= 1'b0;
                    if (!level) begin
                        hold <= '0;
                    end else if (tick && (hold != HW'(LONG_PRESS_MS))) begin
                        hold       <= hold + 1'b1;
                        long_pulse <= (hold == HW'(LONG_PRESS_MS - 1));
                    end
                end
            end
        end else begin : g_no_long
            assign long_pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button debouncer sharing one 1 ms tick prescaler across all channels.
// Latency: SYNC_STAGES + ((DEBOUNCE_MS-1)*TICK_DIV+1 .. DEBOUNCE_MS*TICK_DIV) cycles per accepted edge.
// Backpressure: none; outputs are levels and single-cycle pulses.
//   clk, rst_n  : clock and asynchronous active-low reset (release is synchronised internally)
//   btn_in      : raw asynchronous button inputs
//   btn_state   : debounced levels; btn_press / btn_release / btn_long : single-cycle events
module multi_button_debouncer
    import btn_debounce_pkg::*;
#(
    parameter int NUM_BTNS      = 4,
    parameter int CLK_FREQ      = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_long
);

    localparam int TICK_DIV = tick_div(CLK_FREQ);
    localparam int PW       = cnt_width(TICK_DIV - 1);

    generate
        if (CLK_FREQ < 1000)  begin : g_err_clk  $error("CLK_FREQ must be >= 1000");  end
        if (DEBOUNCE_MS < 1)  begin : g_err_deb  $error("DEBOUNCE_MS must be >= 1");  end
        if (SYNC_STAGES < 2)  begin : g_err_sync $error("SYNC_STAGES must be >= 2");  end
        if (NUM_BTNS < 1)     begin : g_err_num  $error("NUM_BTNS must be >= 1");     end
    endgenerate

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    logic [RST_SYNC_STAGES-1:0] rst_pipe;
    logic                       rst_core_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[RST_SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_core_n = rst_pipe[RST_SYNC_STAGES-1];

    // Shared prescaler: tick is high on the last count before the wrap.
    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_MS  (DEBOUNCE_MS),
                .LONG_PRESS_MS(LONG_PRESS_MS),
                .SYNC_STAGES  (SYNC_STAGES),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_core_n),
                .raw          (btn_in[i]),
                .tick         (tick),
                .level        (btn_state[i]),
                .press_pulse  (btn_press[i]),
                .release_pulse(btn_release[i]),
                .long_pulse   (btn_long[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus random bouncing against a tick-level model.
// An active-high and an active-low instance run side by side on complementary inputs.
// Both must match the same model every cycle.
module tb_multi_button_debouncer;

    localparam int NB   = 4;
    localparam int TICK = 10;   // CLK_FREQ 10_000 -> one tick per 10 cycles
    localparam int DEB  = 3;
    localparam int LONG = 8;
    localparam int RST_EDGES = 2; // edges after rst_n rises before the core leaves reset

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_in_b;
    logic [NB-1:0] st_a, pr_a, rl_a, lg_a;
    logic [NB-1:0] st_b, pr_b, rl_b, lg_b;

    assign btn_in_b = ~btn_in;

    multi_button_debouncer #(
        .NUM_BTNS(NB), .CLK_FREQ(10_000), .DEBOUNCE_MS(DEB),
        .LONG_PRESS_MS(LONG), .SYNC_STAGES(2), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_state(st_a), .btn_press(pr_a), .btn_release(rl_a), .btn_long(lg_a)
    );

    multi_button_debouncer #(
        .NUM_BTNS(NB), .CLK_FREQ(10_000), .DEBOUNCE_MS(DEB),
        .LONG_PRESS_MS(LONG), .SYNC_STAGES(2), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in_b),
        .btn_state(st_b), .btn_press(pr_b), .btn_release(rl_b), .btn_long(lg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model, tick-level: counts ticks of continuous disagreement and ticks held.
    logic [NB-1:0] m_state, m_press, m_rel, m_long;
    int            td[NB];
    int            held[NB];
    int            ecount;
    int            skip;
    logic [NB-1:0] hist[$];

    int press_cnt[NB], rel_cnt[NB], long_cnt[NB];
    int press_cyc[NB], long_cyc[NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_range(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_state = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < NB; i++) begin
            td[i]   = 0;
            held[i] = 0;
        end
        ecount = 0;
        skip   = RST_EDGES;
        hist.delete();
    endtask

    task automatic model_edge();
        logic [NB-1:0] s;
        bit            tk;
        if (!rst_n) begin
            model_reset();
        end else if (skip > 0) begin
            skip--;
        end else begin
            // Synchronised input seen this cycle is the raw value sampled two edges ago.
            s  = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
            tk = ((ecount % TICK) == TICK - 1);
            m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < NB; i++) begin
                if (!m_state[i]) begin
                    held[i] = 0;
                end else if (tk && held[i] < LONG) begin
                    held[i]++;
                    if (held[i] == LONG) m_long[i] = 1'b1;
                end
                if (s[i] == m_state[i]) begin
                    td[i] = 0;
                end else if (tk) begin
                    td[i]++;
                    if (td[i] == DEB) begin
                        td[i]      = 0;
                        m_state[i] = s[i];
                        if (s[i]) m_press[i] = 1'b1;
                        else      m_rel[i]   = 1'b1;
                    end
                end
            end
            hist.push_back(btn_in);
            if (hist.size() > 4) void'(hist.pop_front());
            ecount++;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_cyc[i] = -1; long_cyc[i] = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("state_a",   32'(st_a), 32'(m_state));
        chk("press_a",   32'(pr_a), 32'(m_press));
        chk("release_a", 32'(rl_a), 32'(m_rel));
        chk("long_a",    32'(lg_a), 32'(m_long));
        chk("state_b",   32'(st_b), 32'(m_state));
        chk("press_b",   32'(pr_b), 32'(m_press));
        chk("release_b", 32'(rl_b), 32'(m_rel));
        chk("long_b",    32'(lg_b), 32'(m_long));
        for (int i = 0; i < NB; i++) begin
            if (pr_a[i] === 1'b1) begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (rl_a[i] === 1'b1) rel_cnt[i]++;
            if (lg_a[i] === 1'b1) begin long_cnt[i]++; long_cyc[i] = cyc; end
        end
    endtask

    task automatic wait_level(input string tag, input int ch, input logic val,
                              input int budget, output int lat);
        lat = 0;
        while (st_a[ch] !== val && lat < budget) begin
            step();
            lat++;
        end
        chk(tag, 32'(st_a[ch]), 32'(val));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, 32'({st_a, st_b}), 32'h0);
        chk({tag, "_pulse"}, 32'({pr_a, rl_a, lg_a, pr_b, rl_b, lg_b}), 32'h0);
    endtask

    initial begin
        int lat, rise_cyc, any_pulse, dur[NB];
        bit seen;

        // 1: reset with inputs held high, then quiet release.
        model_reset();
        clear_counts();
        rst_n  = 1'b0;
        btn_in = 4'hF;
        #23;
        check_all_zero("t1_reset");
        repeat (3) step();
        btn_in = 4'h0;
        rst_n  = 1'b1;
        repeat (200) step();
        any_pulse = 0;
        for (int i = 0; i < NB; i++) any_pulse += press_cnt[i] + rel_cnt[i] + long_cnt[i];
        chk("t1_quiet_pulses", 32'(any_pulse), 32'd0);

        // 2: clean press on ch0.
        clear_counts();
        btn_in[0] = 1'b1;
        wait_level("t2_rise", 0, 1'b1, 60, lat);
        chk_range("t2_latency", lat, 23, 32);
        chk("t2_al_state", 32'(st_b[0]), 32'd1);
        repeat (5) step();
        chk("t2_press_cnt0", 32'(press_cnt[0]), 32'd1);
        chk("t2_others", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

        // 3: ch1 bounces every 7 cycles, then settles high.
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            btn_in[1] = (k % 2 == 0);
            repeat (7) begin
                step();
                if (st_a[1] !== 1'b0) seen = 1'b1;
            end
        end
        chk("t3_bounce_state", 32'(seen), 32'd0);
        clear_counts();
        btn_in[1] = 1'b1;
        wait_level("t3_settle", 1, 1'b1, 60, lat);
        repeat (5) step();
        chk("t3_press_cnt1", 32'(press_cnt[1]), 32'd1);

        // 4: long press on ch2.
        btn_in = 4'h0;
        repeat (60) step();
        clear_counts();
        btn_in[2] = 1'b1;
        wait_level("t4_rise", 2, 1'b1, 60, lat);
        rise_cyc = cyc;
        repeat (150) step();
        chk("t4_long_cnt2", 32'(long_cnt[2]), 32'd1);
        chk_range("t4_long_delay", long_cyc[2] - rise_cyc, 71, 80);

        // 5: release after long press.
        clear_counts();
        btn_in[2] = 1'b0;
        wait_level("t5_fall", 2, 1'b0, 60, lat);
        repeat (100) step();
        chk("t5_release_cnt2", 32'(rel_cnt[2]), 32'd1);
        chk("t5_no_long", 32'(long_cnt[2]), 32'd0);

        // 6: ch0 and ch3 together.
        clear_counts();
        btn_in = 4'b1001;
        repeat (50) step();
        chk("t6_press0", 32'(press_cnt[0]), 32'd1);
        chk("t6_press3", 32'(press_cnt[3]), 32'd1);
        chk("t6_same_cycle", 32'(press_cyc[0]), 32'(press_cyc[3]));

        // 7: reset while ch0 is mid-debounce and ch3 is held.
        btn_in = 4'b1000;
        repeat (60) step();
        btn_in = 4'b1001;
        repeat (15) step();
        chk("t7_mid_debounce", 32'(st_a[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("t7_reset");
        repeat (3) step();
        clear_counts();
        rst_n = 1'b1;
        repeat (60) step();
        chk("t7_press0", 32'(press_cnt[0]), 32'd1);
        chk("t7_press3", 32'(press_cnt[3]), 32'd1);
        chk("t7_no_release", 32'(rel_cnt[0] + rel_cnt[3]), 32'd0);

        // Random bouncing on all channels, with one reset in the middle.
        for (int i = 0; i < NB; i++) dur[i] = $urandom_range(1, 40);
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NB; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    btn_in[i] = ~btn_in[i];
                    dur[i]    = $urandom_range(1, 40);
                end
            end
            rst_n = !(c >= 1200 && c < 1203);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
